// File: rtl/dir_pkg.sv
// Shared constants and read-FSM state encoding for the direction-register block.
package dir_pkg;

  localparam int unsigned DIR_DATA_W = 8;
  localparam int unsigned DIR_N_REG  = 4;
  localparam int unsigned DIR_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dir_rd_state_t;

endpackage

// File: rtl/dir_reg_reader_if.sv
// Host-side read bus of the direction-register reader: request in, beat handshake out.
interface dir_reg_reader_if;
  import dir_pkg::*;

  logic [DIR_ADDR_W-1:0] D;
  logic                  strob_in;
  logic                  choose_dir_reg;
  logic                  burst;
  logic [DIR_DATA_W-1:0] rd_data;
  logic [DIR_ADDR_W-1:0] rd_addr;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  rd_ack;
  logic                  busy;
  logic                  overrun;

  modport master (
    output D, strob_in, choose_dir_reg, burst, rd_ack,
    input  rd_data, rd_addr, rd_valid, rd_last, busy, overrun
  );

  modport slave (
    input  D, strob_in, choose_dir_reg, burst, rd_ack,
    output rd_data, rd_addr, rd_valid, rd_last, busy, overrun
  );
endinterface

// File: rtl/dir_reg_reader.sv
// Returns direction-register contents to the host after a programmable latency,
// optionally walking the remaining registers as a burst.
module dir_reg_reader
  import dir_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIR_N_REG*DIR_DATA_W-1:0]  dir_reg_q,
  dir_reg_reader_if.slave                  bus
);

  localparam int unsigned DATA_W = DIR_DATA_W;
  localparam int unsigned ADDR_W = DIR_ADDR_W;
  localparam int unsigned CNT_W  = 4;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = ZERO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DIR_N_REG - 1);

  dir_rd_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              burst_q, burst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              req;
  logic              sample;
  logic [ADDR_W-1:0] sample_addr;
  logic              sample_burst;

  // Next-state, counter and beat-capture logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    cnt_d        = cnt_q;
    rd_data_d    = rd_data_q;
    rd_addr_d    = rd_addr_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    overrun_d    = overrun_q;
    sample       = 1'b0;
    sample_addr  = addr_q;
    sample_burst = burst_q;
    req          = bus.strob_in & bus.choose_dir_reg;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d    = bus.D;
          burst_d   = bus.burst;
          overrun_d = 1'b0;
          if (ZERO_WAIT) begin
            sample       = 1'b1;
            sample_addr  = bus.D;
            sample_burst = bus.burst;
            state_d      = RESP;
          end else begin
            cnt_d   = CNT_RELOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (req) overrun_d = 1'b1;
        if (cnt_q == '0) begin
          sample  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (req) overrun_d = 1'b1;
        if (rd_valid_q && bus.rd_ack) begin
          rd_valid_d = 1'b0;
          if (!rd_last_q) begin
            addr_d = addr_q + ADDR_W'(1);
            if (ZERO_WAIT) begin
              sample      = 1'b1;
              sample_addr = addr_q + ADDR_W'(1);
            end else begin
              cnt_d   = CNT_RELOAD;
              state_d = WAIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Snapshot of the selected register; held until the host acks it
    if (sample) begin
      rd_data_d  = dir_reg_q[sample_addr*DATA_W +: DATA_W];
      rd_addr_d  = sample_addr;
      rd_valid_d = 1'b1;
      rd_last_d  = !sample_burst || (sample_addr == LAST_ADDR);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      burst_q    <= 1'b0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule
